mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states,
// requester ids and the read-latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. When both requesters ask, the one that was not
// granted last wins; a lone requester always wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = last;
    case (req)
      2'b01:   gnt = REQ_CPU;
      2'b10:   gnt = REQ_LD;
      2'b11:   gnt = ~last;
      default: gnt = last;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single CPU memory port between the CPU controller and the
// program loader; one access in flight at a time, fixed read latency.
//
//  state | meaning
//  IDLE  | sample requests, latch the winner's command
//  ISSUE | mem_en strobe for one cycle, load latency counter
//  WAIT  | count down read latency, capture rdata on last cycle
//  DONE  | done pulse to the granted requester, advance pointer
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

  arb_state_t        state;
  logic              cmd_we;
  logic              gnt_id;
  logic              last_gnt;
  logic [LAT_W-1:0]  cnt;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req  ({ld_req, cpu_req}),
    .last (last_gnt),
    .gnt  (pick)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick == REQ_LD) begin
      sel_we    = ld_we;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end
  end

  // mem_addr/mem_wdata double as the latched command; they hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      gnt_id    <= REQ_CPU;
      last_gnt  <= REQ_LD;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
      cpu_done  <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ld_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            gnt_id    <= pick;
            cmd_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= LAT_LOAD;
          state  <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (!cmd_we) begin
              if (gnt_id == REQ_LD) ld_rdata  <= mem_rdata;
              else                  cpu_rdata <= mem_rdata;
            end
            cpu_done <= (gnt_id == REQ_CPU);
            ld_done  <= (gnt_id == REQ_LD);
            state    <= DONE;
          end
        end
        DONE: begin
          last_gnt <= gnt_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected
// memory commands and completions; a monitor pops and compares them.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        who;
    logic [31:0] cpu_rd;
    logic [31:0] ld_rd;
  } done_t;

  logic        clk, reset;
  logic        cpu_req, cpu_we, cpu_done;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ld_req, ld_we, ld_done;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_req, l1_cpu_done, l1_ld_done, l1_mem_en, l1_mem_we;
  logic [31:0] l1_cpu_rdata, l1_ld_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l15_req, l15_cpu_done, l15_ld_done, l15_mem_en, l15_mem_we;
  logic [31:0] l15_cpu_rdata, l15_ld_rdata, l15_mem_addr, l15_mem_wdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  cmd_t  cmd_q[$];
  done_t done_q[$];
  int    en_cycles[$];
  logic [31:0] mem_model [logic [31:0]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .cpu_req(l1_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_rdata(l1_cpu_rdata), .cpu_done(l1_cpu_done),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0),
    .ld_rdata(l1_ld_rdata), .ld_done(l1_ld_done),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(32'hC0DE_0001)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .reset(reset),
    .cpu_req(l15_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_rdata(l15_cpu_rdata), .cpu_done(l15_cpu_done),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0),
    .ld_rdata(l15_ld_rdata), .ld_done(l15_ld_done),
    .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
    .mem_rdata(32'hC0DE_000F)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) fail_now(name, act, exp);
    else vectors++;
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic push_done(input logic who, input logic [31:0] cpu_rd, input logic [31:0] ld_rd);
    done_t e;
    e.who = who; e.cpu_rd = cpu_rd; e.ld_rd = ld_rd;
    done_q.push_back(e);
  endtask

  // Requester model: hold req until done, drop it on the following edge.
  task automatic access(input logic who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat);
    int d;
    if (who == REQ_LD) begin
      ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    d = 0;
    while (!((who == REQ_LD) ? ld_done : cpu_done) && d < 100) begin
      @(posedge clk); #1;
      d++;
    end
    if (d >= 100) fail_now("done_timeout", 32'(d), 32'(exp_lat));
    else if (exp_lat > 0) check("req_to_done_cycles", 32'(d), 32'(exp_lat));
    @(posedge clk); #1;
    if (who == REQ_LD) ld_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_ld_rdata"}, ld_rdata, 32'd0);
    check({tag, "_cpu_done"}, {31'b0, cpu_done}, 32'd0);
    check({tag, "_ld_done"}, {31'b0, ld_done}, 32'd0);
  endtask

  // Memory: read data valid only in the MEM_LAT-th cycle after the strobe.
  initial begin : mem_resp
    int rd_cd;
    logic [31:0] rd_data;
    rd_cd = 0;
    rd_data = '0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      mem_rdata = (rd_cd == 1) ? rd_data : 32'hBAD0_BAD0;
      if (rd_cd != 0) rd_cd--;
      if (mem_en) begin
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else begin
          rd_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr;
          rd_cd = MEM_LAT;
        end
      end
    end
  end

  initial begin : monitor
    cmd_t  c;
    done_t e;
    int    last_en;
    last_en = 0;
    forever begin
      @(negedge clk);
      if (!mem_en) check("mem_we_without_en", {31'b0, mem_we}, 32'd0);
      if (mem_en) begin
        en_cycles.push_back(cyc);
        last_en = cyc;
        if (cmd_q.size() == 0) fail_now("unexpected_mem_en", mem_addr, 32'd0);
        else begin
          c = cmd_q.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, c.we});
          check("mem_addr", mem_addr, c.addr);
          check("mem_wdata", mem_wdata, c.wdata);
        end
      end
      if (cpu_done || ld_done) begin
        if (done_q.size() == 0) fail_now("unexpected_done", {30'b0, ld_done, cpu_done}, 32'd0);
        else begin
          e = done_q.pop_front();
          check("cpu_done", {31'b0, cpu_done}, {31'b0, e.who == REQ_CPU});
          check("ld_done", {31'b0, ld_done}, {31'b0, e.who == REQ_LD});
          check("cpu_rdata", cpu_rdata, e.cpu_rd);
          check("ld_rdata", ld_rdata, e.ld_rd);
          check("en_to_done_cycles", 32'(cyc - last_en), 32'(MEM_LAT + 1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    l1_req = 0; l15_req = 0;
    mem_model[32'h40]  = 32'hDEAD_BEEF;
    mem_model[32'h80]  = 32'h1111_AAAA;
    mem_model[32'h84]  = 32'h3333_CCCC;
    mem_model[32'h180] = 32'h2222_BBBB;
    mem_model[32'h184] = 32'h4444_DDDD;

    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // single CPU read
    push_cmd(1'b0, 32'h40, 32'h5555_5555);
    push_done(REQ_CPU, 32'hDEAD_BEEF, 32'h0);
    access(REQ_CPU, 1'b0, 32'h40, 32'h5555_5555, MEM_LAT + 2);
    check("cpu_rdata_after_done", cpu_rdata, 32'hDEAD_BEEF);

    // loader write leaves both rdata registers alone
    push_cmd(1'b1, 32'h100, 32'h1234_5678);
    push_done(REQ_LD, 32'hDEAD_BEEF, 32'h0);
    access(REQ_LD, 1'b1, 32'h100, 32'h1234_5678, MEM_LAT + 2);

    // both held high: grants alternate CPU, LD, CPU, LD
    en_cycles.delete();
    push_cmd(1'b0, 32'h80, 32'h0);  push_done(REQ_CPU, 32'h1111_AAAA, 32'h0);
    push_cmd(1'b0, 32'h180, 32'h0); push_done(REQ_LD, 32'h1111_AAAA, 32'h2222_BBBB);
    push_cmd(1'b0, 32'h84, 32'h0);  push_done(REQ_CPU, 32'h3333_CCCC, 32'h2222_BBBB);
    push_cmd(1'b0, 32'h184, 32'h0); push_done(REQ_LD, 32'h3333_CCCC, 32'h4444_DDDD);
    fork
      begin
        access(REQ_CPU, 1'b0, 32'h80, 32'h0, 0);
        access(REQ_CPU, 1'b0, 32'h84, 32'h0, 0);
      end
      begin
        access(REQ_LD, 1'b0, 32'h180, 32'h0, 0);
        access(REQ_LD, 1'b0, 32'h184, 32'h0, 0);
      end
    join
    check("tie_en_count", 32'(en_cycles.size()), 32'd4);
    if (en_cycles.size() == 4)
      for (int i = 1; i < 4; i++)
        check("tie_en_spacing", 32'(en_cycles[i] - en_cycles[i-1]), 32'(MEM_LAT + 3));

    // address change after the grant is ignored
    push_cmd(1'b0, 32'h100, 32'h0);
    push_done(REQ_LD, 32'h3333_CCCC, 32'h1234_5678);
    fork
      access(REQ_LD, 1'b0, 32'h100, 32'h0, MEM_LAT + 2);
      begin
        @(posedge clk); @(posedge clk); #2;
        ld_addr = 32'h200;
        d = 0;
        do begin
          @(negedge clk);
          check("mem_addr_hold", mem_addr, 32'h100);
          d++;
        end while (!ld_done && d < 10);
      end
    join

    // CPU write: last grant becomes CPU
    push_cmd(1'b1, 32'h44, 32'hCAFE_F00D);
    push_done(REQ_CPU, 32'h3333_CCCC, 32'h1234_5678);
    access(REQ_CPU, 1'b1, 32'h44, 32'hCAFE_F00D, MEM_LAT + 2);

    // reset during WAIT: no done, pointer back to LD so CPU wins the tie
    push_cmd(1'b0, 32'h48, 32'h0);
    cpu_we = 1'b0; cpu_addr = 32'h48; cpu_wdata = 32'h0; cpu_req = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    #1 check_outputs_zero("reset_in_wait");
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h180; ld_wdata = 32'h0;
    cpu_addr = 32'h80;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    push_cmd(1'b0, 32'h80, 32'h0);  push_done(REQ_CPU, 32'h1111_AAAA, 32'h0);
    push_cmd(1'b0, 32'h180, 32'h0); push_done(REQ_LD, 32'h1111_AAAA, 32'h2222_BBBB);
    fork
      access(REQ_CPU, 1'b0, 32'h80, 32'h0, 0);
      access(REQ_LD, 1'b0, 32'h180, 32'h0, 0);
    join

    // latency extremes on the MEM_LAT=1 and MEM_LAT=15 builds
    fork
      begin
        l1_req = 1'b1; d = 0;
        while (!l1_cpu_done && d < 40) begin @(posedge clk); #1; d++; end
        check("l1_req_to_done", 32'(d), 32'd3);
        check("l1_cpu_rdata", l1_cpu_rdata, 32'hC0DE_0001);
        check("l1_ld_done", {31'b0, l1_ld_done}, 32'd0);
        check("l1_mem_cmd", {l1_mem_en, l1_mem_we, l1_mem_addr[14:0], l1_mem_wdata[14:0]}, 32'd0);
        check("l1_ld_rdata", l1_ld_rdata, 32'd0);
        @(posedge clk); #1 l1_req = 1'b0;
      end
      begin : lat15
        int d15;
        l15_req = 1'b1; d15 = 0;
        while (!l15_cpu_done && d15 < 40) begin @(posedge clk); #1; d15++; end
        check("l15_req_to_done", 32'(d15), 32'd17);
        check("l15_cpu_rdata", l15_cpu_rdata, 32'hC0DE_000F);
        check("l15_ld_done", {31'b0, l15_ld_done}, 32'd0);
        check("l15_mem_cmd", {l15_mem_en, l15_mem_we, l15_mem_addr[14:0], l15_mem_wdata[14:0]}, 32'd0);
        check("l15_ld_rdata", l15_ld_rdata, 32'd0);
        @(posedge clk); #1 l15_req = 1'b0;
      end
    join

    repeat (4) @(posedge clk);
    #1;
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
